// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: address regions, FSM states
// and the small address-decode helper used by the top level.
package mio_pkg;

   // Word width of the CPU data bus, the GPIO register and the counter.
   localparam int DATA_W = 32;

   // Width of the RAM wait-state down-counter. It covers wait counts 0..15.
   localparam int WAIT_W = 4;

   // Top address nibbles that select the peripheral regions.
   // Every other nibble (0x0..0xD) falls into RAM.
   localparam logic [3:0] GPIO_BASE = 4'hE;
   localparam logic [3:0] CNT_BASE  = 4'hF;

   typedef enum logic [1:0] {
      RGN_RAM,
      RGN_GPIO,
      RGN_CNT
   } region_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   // Map the top address nibble onto the region it selects.
   function automatic region_t decodeRegion(input logic [3:0] nibble);
      region_t region;
      case (nibble)
         GPIO_BASE: region = RGN_GPIO;
         CNT_BASE:  region = RGN_CNT;
         default:   region = RGN_RAM;
      endcase
      return region;
   endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter with a synchronous load port. It wraps
// naturally at 2^32, and a load takes priority over the increment.
module mio_counter
   import mio_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_loadValue,
   output logic [DATA_W-1:0] o_count
);

   logic [DATA_W-1:0] r_count;

   // The counter advances every cycle. When a load arrives in that same
   // cycle, the load value replaces the increment.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else begin
         r_count <= r_count + DATA_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO handshake responder. It decodes CPU word accesses to on-chip RAM, the
// GPIO register or the free-running counter, and it closes each request
// with a single-cycle mio_ready pulse.
module mio_bus_responder
   import mio_pkg::*;
#(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = 1
)(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_cpu_mio,
   input  logic [31:0]       i_addr,
   input  logic [DATA_W-1:0] i_data_in,
   output logic              o_mio_ready,
   output logic [DATA_W-1:0] o_data_out,
   output logic [RAM_AW-1:0] o_ram_addr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   input  logic [DATA_W-1:0] i_gpio_in,
   output logic [DATA_W-1:0] o_gpio_out,
   output logic              o_bus_err
);

   state_t              r_state;
   region_t             r_region;
   logic                r_isWrite;
   logic [DATA_W-1:0]   r_wdata;
   logic [WAIT_W-1:0]   r_waitCnt;
   logic                r_mioReady;
   logic [DATA_W-1:0]   r_dataOut;
   logic [RAM_AW-1:0]   r_ramAddr;
   logic                r_ramWe;
   logic [DATA_W-1:0]   r_gpioOut;
   logic                r_busErr;

   logic                w_request;
   region_t             w_region;
   logic                w_cntLoad;
   logic [DATA_W-1:0]   w_count;
   logic                w_ramBypass;
   logic                w_unusedAddr;

   // A request exists only while the CPU qualifies it with cpu_mio. When
   // read and write are both high, the access is treated as a write.
   assign w_request = i_cpu_mio & (i_mem_read | i_mem_write);
   assign w_region  = decodeRegion(i_addr[31:28]);

   // RAM addresses above the implemented size alias onto it, so the
   // middle address bits are dropped along with the byte offset.
   assign w_unusedAddr = ^{i_addr[27:RAM_AW+2], i_addr[1:0]};

   // The counter takes its load in the ACCESS cycle of a counter write.
   assign w_cntLoad = (r_state == ACCESS) && (r_region == RGN_CNT) && r_isWrite;

   // With zero RAM wait states, the synchronous RAM data only arrives in the
   // RESP cycle itself. It is passed straight through for that one cycle and
   // then held in r_dataOut.
   assign w_ramBypass = (RAM_WAIT == 0) && (r_state == RESP) &&
                        (r_region == RGN_RAM) && !r_isWrite;

   mio_counter u_counter (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_load      (w_cntLoad),
      .i_loadValue (r_wdata),
      .o_count     (w_count)
   );

   // Main handshake FSM. It latches the request in IDLE, performs the access
   // in ACCESS, burns RAM wait states in WAIT, then pulses ready in RESP.
   // Every output is registered here, so an asynchronous reset drops ram_we
   // and mio_ready immediately.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_region   <= RGN_RAM;
         r_isWrite  <= 1'b0;
         r_wdata    <= '0;
         r_waitCnt  <= '0;
         r_mioReady <= 1'b0;
         r_dataOut  <= '0;
         r_ramAddr  <= '0;
         r_ramWe    <= 1'b0;
         r_gpioOut  <= '0;
         r_busErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_mioReady <= 1'b0;
               r_ramWe    <= 1'b0;
               if (w_request) begin
                  r_region  <= w_region;
                  r_isWrite <= i_mem_write;
                  r_wdata   <= i_data_in;
                  if (w_region == RGN_RAM) begin
                     r_ramAddr <= i_addr[RAM_AW+1:2];
                     r_ramWe   <= i_mem_write;
                  end
                  if (i_mem_read && i_mem_write) begin
                     r_busErr <= 1'b1;
                  end
                  r_state <= ACCESS;
               end
            end

            ACCESS: begin
               r_ramWe <= 1'b0;
               case (r_region)
                  RGN_GPIO: begin
                     if (r_isWrite) begin
                        r_gpioOut <= r_wdata;
                     end else begin
                        r_dataOut <= i_gpio_in;
                     end
                     r_mioReady <= 1'b1;
                     r_state    <= RESP;
                  end
                  RGN_CNT: begin
                     if (!r_isWrite) begin
                        r_dataOut <= w_count;
                     end
                     r_mioReady <= 1'b1;
                     r_state    <= RESP;
                  end
                  default: begin
                     if (RAM_WAIT > 0) begin
                        r_waitCnt <= WAIT_W'(RAM_WAIT - 1);
                        r_state   <= WAIT;
                     end else begin
                        r_mioReady <= 1'b1;
                        r_state    <= RESP;
                     end
                  end
               endcase
            end

            WAIT: begin
               if (r_waitCnt == '0) begin
                  if (!r_isWrite) begin
                     r_dataOut <= i_ram_rdata;
                  end
                  r_mioReady <= 1'b1;
                  r_state    <= RESP;
               end else begin
                  r_waitCnt <= r_waitCnt - WAIT_W'(1);
               end
            end

            RESP: begin
               r_mioReady <= 1'b0;
               if (w_ramBypass) begin
                  r_dataOut <= i_ram_rdata;
               end
               r_state <= IDLE;
            end

            default: begin
               r_mioReady <= 1'b0;
               r_ramWe    <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign o_mio_ready = r_mioReady;
   assign o_data_out  = w_ramBypass ? i_ram_rdata : r_dataOut;
   assign o_ram_addr  = r_ramAddr;
   assign o_ram_we    = r_ramWe;
   assign o_ram_wdata = r_wdata;
   assign o_gpio_out  = r_gpioOut;
   assign o_bus_err   = r_busErr;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder. A vector table covers the plain RAM
// and GPIO accesses. Hand-written sequences cover the counter wrap,
// back-to-back requests, read+write collisions and mid-access reset.
module tb_mio_bus_responder;

   localparam int RAM_AW = 10;

   logic              clk;
   logic              reset_n;
   logic              memRead;
   logic              memWrite;
   logic              cpuMio;
   logic [31:0]       addr;
   logic [31:0]       dataIn;
   logic              mioReady;
   logic [31:0]       dataOut;
   logic [RAM_AW-1:0] ramAddr;
   logic              ramWe;
   logic [31:0]       ramWdata;
   logic [31:0]       ramRdata;
   logic [31:0]       gpioIn;
   logic [31:0]       gpioOut;
   logic              busErr;

   int checkCount = 0;
   int failCount  = 0;
   int readyCount = 0;
   int weCount    = 0;

   logic [31:0] mem [1024] = '{default: 32'h0};

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] gpio;
      int          expLat;
      logic [31:0] expData;
      logic        expWe;
      logic [9:0]  expWeAddr;
   } vec_t;

   vec_t vecs [7];

   mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(1)) dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_mem_read  (memRead),
      .i_mem_write (memWrite),
      .i_cpu_mio   (cpuMio),
      .i_addr      (addr),
      .i_data_in   (dataIn),
      .o_mio_ready (mioReady),
      .o_data_out  (dataOut),
      .o_ram_addr  (ramAddr),
      .o_ram_we    (ramWe),
      .o_ram_wdata (ramWdata),
      .i_ram_rdata (ramRdata),
      .i_gpio_in   (gpioIn),
      .o_gpio_out  (gpioOut),
      .o_bus_err   (busErr)
   );

   // 100 MHz-style clock, 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (ramWe === 1'b1) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
   end

   // Count ready pulses and RAM write strobes on each clock edge.
   always @(posedge clk) begin
      if (mioReady === 1'b1) readyCount++;
      if (ramWe === 1'b1) weCount++;
   end

   // Safety net in case the whole run stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   // Issue one request in an IDLE cycle and wait for mio_ready. Return the
   // number of edges to ready (-1 on timeout), data_out at ready, and
   // ram_we/ram_addr as seen in the ACCESS cycle. Return one cycle later,
   // when the DUT is back in IDLE.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] g, output int lat,
                                output logic [31:0] dout, output logic weSeen,
                                output logic [9:0] weAddrSeen);
      @(negedge clk);
      memRead  = rd;
      memWrite = wr;
      cpuMio   = 1'b1;
      addr     = a;
      dataIn   = d;
      gpioIn   = g;
      lat        = -1;
      dout       = 32'h0;
      weSeen     = 1'b0;
      weAddrSeen = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            weSeen     = ramWe;
            weAddrSeen = ramAddr;
         end
         if (mioReady === 1'b1) begin
            lat  = c;
            dout = dataOut;
            break;
         end
      end
      memRead  = 1'b0;
      memWrite = 1'b0;
      cpuMio   = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int          lat;
   int          lat2;
   int          rdyBefore;
   int          weBefore;
   logic [31:0] dout;
   logic [31:0] dout2;
   logic        weSeen;
   logic [9:0]  weAddrSeen;
   logic [31:0] cntLoad;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h1111_1111, 3, 32'h0000_0000, 1'b1, 10'd4};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1111_1111, 3, 32'h1234_5678, 1'b0, 10'd0};
      vecs[2] = '{1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h1111_1111, 2, 32'h1234_5678, 1'b0, 10'd0};
      vecs[3] = '{1'b1, 1'b0, 32'hE000_0004, 32'h0000_0000, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 10'd0};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 32'h1111_1111, 3, 32'hCAFE_F00D, 1'b1, 10'd4};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1111_1111, 3, 32'hDEAD_BEEF, 1'b0, 10'd0};
      vecs[6] = '{1'b1, 1'b0, 32'hD000_0010, 32'h0000_0000, 32'h1111_1111, 3, 32'hDEAD_BEEF, 1'b0, 10'd0};

      reset_n  = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      cpuMio   = 1'b0;
      addr     = 32'h0;
      dataIn   = 32'h0;
      gpioIn   = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset mio_ready", {31'h0, mioReady}, 32'h0);
      checkOutput("reset data_out", dataOut, 32'h0);
      checkOutput("reset ram_we", {31'h0, ramWe}, 32'h0);
      checkOutput("reset ram_addr", {22'h0, ramAddr}, 32'h0);
      checkOutput("reset ram_wdata", ramWdata, 32'h0);
      checkOutput("reset gpio_out", gpioOut, 32'h0);
      checkOutput("reset bus_err", {31'h0, busErr}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven RAM and GPIO accesses.
      for (int i = 0; i < 7; i++) begin
         rdyBefore = readyCount;
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                       vecs[i].gpio, lat, dout, weSeen, weAddrSeen);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d data_out", i), dout, vecs[i].expData);
         checkOutput($sformatf("vec%0d ram_we", i), {31'h0, weSeen}, {31'h0, vecs[i].expWe});
         if (vecs[i].expWe)
            checkOutput($sformatf("vec%0d ram_addr", i), {22'h0, weAddrSeen}, {22'h0, vecs[i].expWeAddr});
         checkOutput($sformatf("vec%0d ready pulses", i), 32'(readyCount - rdyBefore), 32'd1);
      end
      checkOutput("gpio_out after write", gpioOut, 32'h0000_00A5);
      checkOutput("ram word 4", mem[4], 32'hDEAD_BEEF);
      checkOutput("ram_we pulse total", 32'(weCount), 32'd2);
      checkOutput("bus_err clean", {31'h0, busErr}, 32'h0);

      // Counter load near the top, then read it back after the wrap.
      cntLoad = 32'hFFFF_FFFE;
      applyStimulus(1'b0, 1'b1, 32'hF000_0000, cntLoad, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("cnt write latency", 32'(lat), 32'd2);
      checkOutput("cnt write keeps data_out", dout, 32'hDEAD_BEEF);
      @(posedge clk);
      applyStimulus(1'b1, 1'b0, 32'hF000_0008, 32'h0, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("cnt read latency", 32'(lat), 32'd2);
      checkOutput("cnt read wrapped", dout, cntLoad + 32'd3);

      // Read and write together: handled as a write, and bus_err is raised.
      applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0000_005A, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("rw latency", 32'(lat), 32'd3);
      checkOutput("rw keeps data_out", dout, cntLoad + 32'd3);
      checkOutput("rw ram word 8", mem[8], 32'h0000_005A);
      checkOutput("rw bus_err", {31'h0, busErr}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("rw readback", dout, 32'h0000_005A);
      checkOutput("bus_err sticky", {31'h0, busErr}, 32'h1);

      // Back-to-back: hold the request through RESP, then retarget it.
      rdyBefore = readyCount;
      @(negedge clk);
      memRead = 1'b1; cpuMio = 1'b1; addr = 32'h0000_0010;
      lat = -1; dout = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (mioReady === 1'b1) begin lat = c; dout = dataOut; break; end
      end
      @(posedge clk); #1;
      checkOutput("b2b idle gap", {31'h0, mioReady}, 32'h0);
      addr = 32'h0000_0020;
      lat2 = -1; dout2 = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (mioReady === 1'b1) begin lat2 = c; dout2 = dataOut; break; end
      end
      memRead = 1'b0; cpuMio = 1'b0;
      @(posedge clk); #1;
      checkOutput("b2b first latency", 32'(lat), 32'd3);
      checkOutput("b2b first data", dout, 32'hDEAD_BEEF);
      checkOutput("b2b second latency", 32'(lat2), 32'd3);
      checkOutput("b2b second data", dout2, 32'h0000_005A);
      checkOutput("b2b ready pulses", 32'(readyCount - rdyBefore), 32'd2);

      // Reset during WAIT of a RAM read.
      rdyBefore = readyCount;
      @(negedge clk);
      memRead = 1'b1; cpuMio = 1'b1; addr = 32'h0000_0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      checkOutput("abort mio_ready", {31'h0, mioReady}, 32'h0);
      checkOutput("abort data_out", dataOut, 32'h0);
      checkOutput("abort ram_addr", {22'h0, ramAddr}, 32'h0);
      checkOutput("abort ram_wdata", ramWdata, 32'h0);
      checkOutput("abort gpio_out", gpioOut, 32'h0);
      checkOutput("abort bus_err", {31'h0, busErr}, 32'h0);
      memRead = 1'b0; cpuMio = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort no ready", 32'(readyCount - rdyBefore), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("post-abort latency", 32'(lat), 32'd3);
      checkOutput("post-abort data", dout, 32'h0000_005A);

      // Reset during the ACCESS cycle of a RAM write: ram_we drops at once.
      @(negedge clk);
      memWrite = 1'b1; cpuMio = 1'b1; addr = 32'h0000_0030; dataIn = 32'h0000_0077;
      @(posedge clk); #1;
      checkOutput("access ram_we", {31'h0, ramWe}, 32'h1);
      reset_n = 1'b0;
      #1;
      checkOutput("async ram_we drop", {31'h0, ramWe}, 32'h0);
      memWrite = 1'b0; cpuMio = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("aborted write not committed", mem[12], 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0, lat, dout, weSeen, weAddrSeen);
      checkOutput("aborted write readback", dout, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
